// File: rtl/cl_head_pack.sv
// Transmit-side cache-line packer: packs W_ST-bit STs into CL-bit lines with a
// 16-bit {eof, count} header, and reports each frame's ST count on a sideband.
module cl_head_pack #(
   parameter int unsigned CL        = 512,
   parameter int unsigned CL_HEAD   = 16,
   parameter int unsigned W_ST      = 8,
   parameter int unsigned W_FRM_LEN = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sink_valid,
   output logic                 sink_ready,
   input  logic [W_ST-1:0]      sink_data,
   input  logic                 sink_eop,
   output logic                 source_valid,
   input  logic                 source_ready,
   output logic [CL-1:0]        source_data,
   output logic [W_FRM_LEN-1:0] sb_len,
   output logic                 sb_len_valid
);

   localparam int unsigned CL_PAYLOAD = CL - CL_HEAD;
   localparam int unsigned STS_PER_CL = CL_PAYLOAD / W_ST;
   localparam int unsigned W_CNT      = $clog2(STS_PER_CL);
   localparam int unsigned W_HCNT     = 10;
   localparam int unsigned W_RSVD     = CL_HEAD - W_HCNT - 1;

   typedef struct packed {
      logic [W_RSVD-1:0]     rsvd;
      logic                  eof;
      logic [W_HCNT-1:0]     count;
      logic [CL_PAYLOAD-1:0] payload;
   } cl_t;

   logic [W_CNT-1:0]      cnt;
   logic [CL_PAYLOAD-1:0] asm_buf;
   logic [CL_PAYLOAD-1:0] asm_nxt;
   logic [W_FRM_LEN-1:0]  frm_cnt;
   cl_t                   out_q;
   cl_t                   cl_nxt;
   logic                  accept;
   logic                  close;
   logic                  last_slot;

   // Output slot free or draining this cycle, so a closing ST always has room.
   assign sink_ready  = !source_valid || source_ready;
   assign accept      = sink_valid && sink_ready;
   assign last_slot   = (cnt == W_CNT'(STS_PER_CL - 1));
   assign close       = accept && (last_slot || sink_eop);
   assign source_data = out_q;

   // Merge the incoming ST into its slot and form the line it would close.
   always_comb begin
      asm_nxt                      = asm_buf;
      asm_nxt[cnt * W_ST +: W_ST]  = sink_data;
      cl_nxt                       = '0;
      cl_nxt.eof                   = sink_eop;
      cl_nxt.count                 = W_HCNT'(cnt) + W_HCNT'(1);
      cl_nxt.payload               = asm_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt          <= '0;
         asm_buf      <= '0;
         frm_cnt      <= '0;
         out_q        <= '0;
         source_valid <= 1'b0;
         sb_len       <= '0;
         sb_len_valid <= 1'b0;
      end else begin
         sb_len_valid <= 1'b0;

         if (accept) begin
            if (close) begin
               cnt     <= '0;
               asm_buf <= '0;
            end else begin
               cnt     <= cnt + W_CNT'(1);
               asm_buf <= asm_nxt;
            end

            if (sink_eop) begin
               sb_len       <= frm_cnt + W_FRM_LEN'(1);
               sb_len_valid <= 1'b1;
               frm_cnt      <= '0;
            end else begin
               frm_cnt      <= frm_cnt + W_FRM_LEN'(1);
            end
         end

         // A reload wins over the clear when a transfer and a close coincide.
         if (close) begin
            out_q        <= cl_nxt;
            source_valid <= 1'b1;
         end else if (source_valid && source_ready) begin
            out_q        <= '0;
            source_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/cl_head_pack.md
# cl_head_pack

Transmit-side cache-line packer for the AFU frame path. Accepts a stream of STs (symbols), one per cycle, packs them into 512-bit cache lines, and prepends the 16-bit CL header: end-of-AFU-frame flag plus the ST count for that line. Downstream receive-side header analysis consumes exactly this format. The block also reports the total frame length in STs on a sideband.

## Interface
- CL, 512: cache line width in bits.
- CL_HEAD, 16: header width; header occupies bits [CL-1:CL-16].
- CL_PAYLOAD, 496: payload width; payload occupies bits [CL_PAYLOAD-1:0].
- W_ST, 8: ST width in bits; STS_PER_CL = CL_PAYLOAD/W_ST = 62 (integer division; leftover payload bits are driven 0).
- w_NumOfST_in_AFUFrm, 16: width of the frame-length sideband.

Ports:
- clk  in  1  the single clock.
- rst  in  1  reset; asynchronous, active-high.
- sink_valid  in  1  ST present.
- sink_ready  out  1  block accepts ST; transfer when sink_valid & sink_ready.
- sink_data  in  W_ST  ST value.
- sink_eop  in  1  qualifies the last ST of an AFU frame.
- source_valid  out  1  CL present.
- source_ready  in  1  downstream accepts CL; transfer when source_valid & source_ready.
- source_data  out  CL  packed cache line.
- sb_len  out  w_NumOfST_in_AFUFrm  ST count of the most recently completed frame.
- sb_len_valid  out  1  one-cycle pulse when sb_len updates.

## Operation
- Header layout: bits [CL-1:CL-5] = 0; bit CL-6 = eof; bits [CL-7:CL-16] (10 bits) = ST count of this CL, 1..STS_PER_CL.
- ST k of a CL (k = 0 first accepted) is placed at payload bits [k*W_ST+W_ST-1 : k*W_ST]. Unfilled slots are 0.
- Assembly: an assembly buffer plus slot counter cnt (0..STS_PER_CL-1). Each accepted ST is written to slot cnt.
- A CL closes on an accepted ST when cnt == STS_PER_CL-1 or sink_eop=1. On close: output register loaded with {header, payload including this ST}, eof = sink_eop, count = cnt+1. cnt and the assembly buffer clear to 0.
- Output stage: one register (source_data, source_valid). It is cleared on a source transfer unless it is reloaded in the same cycle.
- sink_ready = !source_valid | source_ready (combinational). The block accepts STs only when the output slot is free or draining, so a closing ST always has room.
- Frame length: frm_cnt accumulates accepted STs, modulo 2^w_NumOfST_in_AFUFrm; longer frames are illegal and wrap. On an accepted ST with sink_eop: sb_len <= frm_cnt+1, sb_len_valid <= 1 for one cycle, frm_cnt <= 0.
- A frame always contains at least one ST, because eop rides on an ST. A frame of N STs yields ceil(N/62) CLs; only the last has eof=1.
- Reset: asynchronous assert clears cnt, frm_cnt, the assembly buffer and the output register. Any partial CL or frame is discarded. Reset values: source_valid 0, source_data 0, sb_len 0, sb_len_valid 0. sink_ready is 1 after reset because no CL is pending.

## Timing
- Latency: a closing ST accepted at edge t gives source_valid=1 after edge t; sb_len/sb_len_valid update at the same edge.
- Throughput: 1 ST/cycle sustained while source_ready=1. Each CL holds source_valid for ≥1 cycle with no bubble on the sink side.
- Backpressure: while source_valid=1 and source_ready=0, source_data and source_valid hold stable, sink_ready=0, and no ST is accepted.
- Simultaneous events: a source transfer and a new close in the same cycle load the new CL (source_valid stays 1). A source transfer without a close clears source_valid.
- sink_eop with sink_valid=0 is ignored.

## Test plan
- Three STs 0x11,0x22,0x33, eop on the third, source_ready=1 -> one CL: data[23:0]=0x332211, bit 506=1, bits[505:496]=3, bits[511:507]=0, all other bits 0. sb_len=3 with a 1-cycle sb_len_valid pulse.
- 62 STs, eop on the last -> one CL with count=62, eof=1, sb_len=62. Then 63 STs -> CL1 count=62 eof=0, CL2 count=1 eof=1 with the 63rd ST at bits[7:0], sb_len=63.
- Backpressure: hold source_ready=0 while a CL is pending and sink_valid=1 -> sink_ready=0 and source_data stable for 20 cycles. Release -> CL consumed, STs resume with no loss or duplication (scoreboard).
- Back-to-back frames: 5-ST frame, then a 70-ST frame starting next cycle, source_ready=1 -> CLs (5,eof1), (62,eof0), (8,eof1). sb_len pulses 5 then 70, and there are no sink-side bubbles.
- Reset mid-frame: assert rst after 10 STs of a frame -> outputs zero immediately. After deassert, a 2-ST frame -> CL count=2, eof=1, sb_len=2, with no residue from the discarded data.
- Random valid/ready throttling over 1000 frames of length 1..300 -> a reference model matches every CL header, payload and sb_len.
